// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges the cache's 256-bit line port to a 64-bit burst
// memory. Each line read or write is split into four beats, lowest beat first.
// One transaction is handled at a time. A single-cycle pmem_resp pulse marks
// completion.
module cacheline_adaptor #(
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4,
  parameter int ADDR_WIDTH = 32,
  localparam int LINE_WIDTH = BEAT_WIDTH * BEATS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  output logic                  pmem_resp,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BEAT_WIDTH-1:0] mem_burst_wdata,
  input  logic [BEAT_WIDTH-1:0] mem_burst_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_resp
);

  localparam int CNT_W       = $clog2(BEATS);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  // Clears the byte-in-line offset so bursts always start on a line boundary.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [LINE_WIDTH-1:0]   line;
  logic                    load_read;
  logic                    load_write;
  logic                    capture_beat;

  // State, beat counter, latched request and assembled read line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      line       <= '0;
      pmem_rdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_write) begin
        addr <= pmem_address & ADDR_MASK;
        line <= pmem_wdata;
      end else if (load_read) begin
        addr <= pmem_address & ADDR_MASK;
      end
      if (capture_beat) begin
        pmem_rdata[int'(cnt) * BEAT_WIDTH +: BEAT_WIDTH] <= mem_burst_rdata;
      end
    end
  end

  // Next-state sequencing and output decode; memory beats only count in READ/WRITE.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    load_read       = 1'b0;
    load_write      = 1'b0;
    capture_beat    = 1'b0;
    pmem_resp       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_burst_wdata = '0;
    case (state)
      IDLE: begin
        // Write takes priority when the cache raises both requests.
        if (pmem_write) begin
          load_write = 1'b1;
          cnt_next   = '0;
          state_next = WRITE;
        end else if (pmem_read) begin
          load_read  = 1'b1;
          cnt_next   = '0;
          state_next = READ;
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        mem_read    = 1'b1;
        mem_address = addr;
        if (mem_resp) begin
          capture_beat = 1'b1;
          cnt_next     = cnt + 1'b1;
          state_next   = (cnt == LAST_BEAT) ? DONE : READ;
        end else begin
          state_next = READ;
        end
      end
      WRITE: begin
        mem_write       = 1'b1;
        mem_address     = addr;
        mem_burst_wdata = line[int'(cnt) * BEAT_WIDTH +: BEAT_WIDTH];
        if (mem_resp) begin
          cnt_next   = cnt + 1'b1;
          state_next = (cnt == LAST_BEAT) ? DONE : WRITE;
        end else begin
          state_next = WRITE;
        end
      end
      DONE: begin
        pmem_resp  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed testbench for cacheline_adaptor. Inputs change 1 time unit after a
// rising edge and outputs are sampled in that same window. "Cycle k" means the
// interval following the k-th edge after a request is first presented.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic [31:0]  mem_address;
  logic [63:0]  mem_burst_wdata;
  logic [63:0]  mem_burst_rdata;
  logic         mem_read;
  logic         mem_write;
  logic         mem_resp;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  cacheline_adaptor dut (
    .clk             (clk),
    .rst             (rst),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_resp       (pmem_resp),
    .pmem_rdata      (pmem_rdata),
    .mem_address     (mem_address),
    .mem_burst_wdata (mem_burst_wdata),
    .mem_burst_rdata (mem_burst_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full read transaction starting in an idle cycle with no request pending.
  task automatic do_read(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_addr, input logic [255:0] ln);
    logic [255:0] l;
    l = ln;
    pmem_read = 1'b1; pmem_write = 1'b0; pmem_address = a; mem_resp = 1'b0;
    check({tag, " idle mem_read"}, 256'(mem_read), 256'd0);
    check({tag, " idle pmem_resp"}, 256'(pmem_resp), 256'd0);
    step();
    for (int b = 0; b < 4; b++) begin
      mem_resp = 1'b1;
      mem_burst_rdata = l[b*64 +: 64];
      pmem_address = 32'hFFFF_FFFF;   // ignored once accepted
      check({tag, " beat mem_read"}, 256'(mem_read), 256'd1);
      check({tag, " beat mem_address"}, 256'(mem_address), 256'(exp_addr));
      check({tag, " beat pmem_resp"}, 256'(pmem_resp), 256'd0);
      check({tag, " beat mem_write"}, 256'(mem_write), 256'd0);
      step();
    end
    mem_resp = 1'b0;
    check({tag, " done pmem_resp"}, 256'(pmem_resp), 256'd1);
    check({tag, " done pmem_rdata"}, pmem_rdata, l);
    check({tag, " done mem_read"}, 256'(mem_read), 256'd0);
    step();
    pmem_read = 1'b0;
    check({tag, " after pmem_resp"}, 256'(pmem_resp), 256'd0);
    check({tag, " after pmem_rdata"}, pmem_rdata, l);
  endtask

  logic [255:0] line_a, line_b, line_e, line_f, line_w, line_s;
  logic [63:0]  wexp [1:10];
  logic         wresp [1:10];

  initial begin
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_w = {64'hCAFE_F00D_5555_AAAA, 64'hDEAD_BEEF_0000_0001,
              64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    line_s = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
              64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
    line_e = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
              64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
    line_f = {64'h0F0F_0000_0000_0004, 64'h0F0F_0000_0000_0003,
              64'h0F0F_0000_0000_0002, 64'h0F0F_0000_0000_0001};
    line_b = {64'hBBBB_0000_BBBB_0004, 64'hBBBB_0000_BBBB_0003,
              64'hBBBB_0000_BBBB_0002, 64'hBBBB_0000_BBBB_0001};

    rst = 1'b1; pmem_address = 32'd0; pmem_wdata = 256'd0;
    pmem_read = 1'b0; pmem_write = 1'b0; mem_burst_rdata = 64'd0; mem_resp = 1'b0;

    // Reset state
    step(); step();
    check("rst pmem_resp", 256'(pmem_resp), 256'd0);
    check("rst mem_read", 256'(mem_read), 256'd0);
    check("rst mem_write", 256'(mem_write), 256'd0);
    check("rst mem_address", 256'(mem_address), 256'd0);
    check("rst mem_burst_wdata", 256'(mem_burst_wdata), 256'd0);
    check("rst pmem_rdata", pmem_rdata, 256'd0);
    rst = 1'b0;
    step();

    // Read, back-to-back beats
    do_read("read1", 32'h0000_1234, 32'h0000_1220, line_a);

    // Write with gaps: resp in cycles 2,5,6,9; data advances after each resp
    wresp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    wexp  = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
              64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210,
              64'hFEDC_BA98_7654_3210, 64'hDEAD_BEEF_0000_0001,
              64'hCAFE_F00D_5555_AAAA, 64'hCAFE_F00D_5555_AAAA,
              64'hCAFE_F00D_5555_AAAA, 64'd0};
    pmem_write = 1'b1; pmem_address = 32'hABCD_EF7F; pmem_wdata = line_w;
    step();
    pmem_wdata = ~line_w;   // ignored once accepted
    for (int c = 1; c <= 10; c++) begin
      mem_resp = wresp[c];
      check("wr mem_burst_wdata", 256'(mem_burst_wdata), 256'(wexp[c]));
      check("wr mem_write", 256'(mem_write), (c <= 9) ? 256'd1 : 256'd0);
      check("wr mem_read", 256'(mem_read), 256'd0);
      check("wr mem_address", 256'(mem_address), (c <= 9) ? 256'h0000_0000_ABCD_EF60 : 256'd0);
      check("wr pmem_resp", 256'(pmem_resp), (c == 10) ? 256'd1 : 256'd0);
      step();
    end
    pmem_write = 1'b0; mem_resp = 1'b0;
    check("wr after pmem_resp", 256'(pmem_resp), 256'd0);
    step();

    // Simultaneous read and write: write burst only
    pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_0100; pmem_wdata = line_s;
    step();
    for (int c = 1; c <= 5; c++) begin
      mem_resp = (c <= 4);
      check("both mem_read", 256'(mem_read), 256'd0);
      check("both mem_write", 256'(mem_write), (c <= 4) ? 256'd1 : 256'd0);
      if (c <= 4) check("both wdata", 256'(mem_burst_wdata), 256'(line_s[(c-1)*64 +: 64]));
      else        check("both pmem_resp", 256'(pmem_resp), 256'd1);
      step();
    end
    pmem_read = 1'b0; pmem_write = 1'b0; mem_resp = 1'b0;
    check("both after mem_read", 256'(mem_read), 256'd0);
    step();

    // Reset mid-read after two beats
    pmem_read = 1'b1; pmem_address = 32'h0000_2000;
    step();
    mem_resp = 1'b1; mem_burst_rdata = 64'h9999_0000_0000_0000;
    step();
    mem_burst_rdata = 64'h9999_0000_0000_0001;
    step();
    mem_resp = 1'b0; rst = 1'b1;
    check("midrst mem_read before", 256'(mem_read), 256'd1);
    step();
    rst = 1'b0; pmem_read = 1'b0;
    check("midrst pmem_resp", 256'(pmem_resp), 256'd0);
    check("midrst mem_read", 256'(mem_read), 256'd0);
    check("midrst mem_write", 256'(mem_write), 256'd0);
    check("midrst mem_address", 256'(mem_address), 256'd0);
    check("midrst mem_burst_wdata", 256'(mem_burst_wdata), 256'd0);
    check("midrst pmem_rdata", pmem_rdata, 256'd0);
    step();
    do_read("post-rst read", 32'h0000_3010, 32'h0000_3000, line_e);

    // Spurious mem_resp in IDLE
    for (int c = 0; c < 3; c++) begin
      mem_resp = 1'b1; mem_burst_rdata = 64'h5A5A_5A5A_0000_0000 + 64'(c);
      step();
      check("spur pmem_resp", 256'(pmem_resp), 256'd0);
      check("spur pmem_rdata", pmem_rdata, line_e);
      check("spur mem_read", 256'(mem_read), 256'd0);
    end
    mem_resp = 1'b0;
    do_read("post-spur read", 32'h0000_567F, 32'h0000_5660, line_f);

    // Two consecutive reads
    do_read("consec read0", 32'h0000_0000, 32'h0000_0000, line_a);
    do_read("consec read1", 32'h0000_0040, 32'h0000_0040, line_b);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache, between the cache's physical-memory port and the burst-oriented main memory.
- Converts a single 256-bit cacheline read or write request into a sequence of four 64-bit memory beats.
- Returns one completion pulse and the assembled line to the cache.
- Handles exactly one outstanding transaction at a time.

Parameters:
- BEAT_WIDTH, 64, bits per memory beat.
- BEATS, 4, beats per cacheline.
- ADDR_WIDTH, 32, address width.
- LINE_WIDTH is derived as BEAT_WIDTH*BEATS (256). It is not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pmem_address  in  ADDR_WIDTH  line address from cache.
- pmem_wdata  in  LINE_WIDTH  line to write.
- pmem_read  in  1  line read request; held by cache until pmem_resp.
- pmem_write  in  1  line write request; held by cache until pmem_resp.
- pmem_resp  out  1  one-cycle completion pulse to cache.
- pmem_rdata  out  LINE_WIDTH  assembled read line.
- mem_address  out  ADDR_WIDTH  line-aligned burst address to memory.
- mem_burst_wdata  out  BEAT_WIDTH  current write beat.
- mem_burst_rdata  in  BEAT_WIDTH  read beat from memory.
- mem_read  out  1  burst read request.
- mem_write  out  1  burst write request.
- mem_resp  in  1  memory beat strobe; one per beat.

Behaviour:
- States: IDLE, READ, WRITE, DONE. A 2-bit beat counter `cnt` tracks progress.
- Reset (synchronous, active-high): state=IDLE, cnt=0.
  - Outputs reset to: pmem_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_burst_wdata=0, pmem_rdata=0.
  - Reset asserted mid-burst aborts the burst immediately. Memory must tolerate the dropped request.
- IDLE:
  - pmem_write=1: latch {pmem_address[31:5], 5'b0} into the address register, latch pmem_wdata, cnt=0, go to WRITE.
  - Else pmem_read=1: latch the aligned address, cnt=0, go to READ.
  - Write wins if both requests are high.
  - No memory outputs are asserted while in IDLE.
- READ:
  - mem_read=1 and mem_address = latched address, held constant for the whole burst.
  - On each cycle with mem_resp=1: store mem_burst_rdata into pmem_rdata[64*cnt +: 64], then cnt++.
  - mem_resp may deassert between beats; the block waits indefinitely.
  - On the 4th beat (cnt==3 with mem_resp=1): go to DONE, cnt wraps to 0, mem_read drops the next cycle.
- WRITE:
  - mem_write=1, mem_address = latched address.
  - mem_burst_wdata = latched line[64*cnt +: 64] (combinational from cnt).
  - Each cycle with mem_resp=1 accepts the current beat, then cnt++.
  - After the 4th accepted beat: go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; next state is IDLE.
  - pmem_rdata is valid in this cycle and holds its value until the next read's first beat overwrites it.
  - The cache must deassert its request in the cycle after pmem_resp. The IDLE entered after DONE samples requests normally.
- Beat order: beat 0 = line bits [63:0], ascending.
- Latency: with a request seen in IDLE at cycle 0 and mem_resp high in cycles 1–4, pmem_resp is asserted in cycle 5.
  - Minimum is 6 cycles request-to-request.
- Request inputs (pmem_address, pmem_wdata) are sampled only in IDLE. Changes after acceptance are ignored.
- mem_resp while in IDLE or DONE is ignored: no counter change, no data capture.

Test Plan:
- Read, back-to-back beats:
  - Stimulus: pmem_read=1, pmem_address=0x0000_1234; memory returns 0x1111…, 0x2222…, 0x3333…, 0x4444… with mem_resp high in cycles 1–4.
  - Required: mem_address=0x0000_1220 throughout; pmem_resp pulses in cycle 5 only; pmem_rdata={0x4444…,0x3333…,0x2222…,0x1111…}.
- Write with gaps:
  - Stimulus: pmem_write=1, pmem_wdata={D3,D2,D1,D0}; mem_resp high in cycles 2, 5, 6, 9.
  - Required: mem_burst_wdata steps D0→D1→D2→D3 only after each resp; mem_write stays high through cycle 9; pmem_resp in cycle 10.
- Simultaneous pmem_read and pmem_write in IDLE:
  - Required: a write burst only; mem_read is never asserted.
- Reset mid-read:
  - Stimulus: rst=1 after 2 beats; then a new read is issued.
  - Required: the next cycle is IDLE with all outputs 0; the new read starts cleanly with cnt=0 and gives correct data.
- Spurious mem_resp in IDLE, followed by a normal read:
  - Required: no pmem_resp, no pmem_rdata change while IDLE; the subsequent read completes with correct data.
- Two consecutive reads:
  - Stimulus: second read to 0x40, issued after the cache drops its request following the first pmem_resp.
  - Required: exactly one pmem_resp per transaction; the second line fully replaces the first.
